// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception sequencer: state encoding, cause codes and
// the memory-address mux select that control drives while the sequencer owns the bus.
package exception_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StWait = 3'd2,
    StLoad = 3'd3,
    StDone = 3'd4
  } exc_state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV0 = 2'b11;

  // MemAdd select used by the main control FSM while ExcBusOwn is high.
  localparam logic [1:0] MEMADD_EXC = 2'b01;

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority encoder: three exception requests to a 2-bit cause and its vector
// byte address. Opcode beats overflow beats divide-by-zero.
module exc_priority_enc
  import exception_sequencer_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE   = 32'd253,
  parameter logic [31:0] VEC_OVERFLOW = 32'd254,
  parameter logic [31:0] VEC_DIVZERO  = 32'd255
) (
  input  logic        opcode_i,
  input  logic        overflow_i,
  input  logic        divzero_i,
  output logic [1:0]  cause_o,
  output logic [31:0] vec_o
);

  always_comb begin
    cause_o = CAUSE_NONE;
    vec_o   = '0;
    if (opcode_i) begin
      cause_o = CAUSE_OPC;
      vec_o   = VEC_OPCODE;
    end else if (overflow_i) begin
      cause_o = CAUSE_OVF;
      vec_o   = VEC_OVERFLOW;
    end else if (divzero_i) begin
      cause_o = CAUSE_DIV0;
      vec_o   = VEC_DIVZERO;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Multicycle exception front-end: saves EPC, reads the handler byte from the vector
// address over the shared memory bus, then loads PC with it. All outputs registered.
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE   = 32'd253,
  parameter logic [31:0] VEC_OVERFLOW = 32'd254,
  parameter logic [31:0] VEC_DIVZERO  = 32'd255,
  parameter int unsigned MEM_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ExcOpcode,
  input  logic        ExcOverflow,
  input  logic        ExcDivZero,
  input  logic [31:0] PC,
  input  logic [31:0] MemData,
  output logic [31:0] ExceptionAddress,
  output logic        ExcBusOwn,
  output logic [31:0] EPCOut,
  output logic        EPCWrite,
  output logic [31:0] PCOut,
  output logic        PCWrite,
  output logic [1:0]  ExcCause,
  output logic        Busy,
  output logic        ExcDone
);

  localparam logic [2:0] WaitInit = 3'(MEM_LATENCY - 1);

  exc_state_e  state_q;
  logic [2:0]  wait_cnt_q;
  logic [1:0]  req_cause;
  logic [31:0] req_vec;
  logic        unused_memdata;

  // Only the handler byte is architecturally meaningful.
  assign unused_memdata = ^MemData[31:8];

  exc_priority_enc #(
    .VEC_OPCODE  (VEC_OPCODE),
    .VEC_OVERFLOW(VEC_OVERFLOW),
    .VEC_DIVZERO (VEC_DIVZERO)
  ) u_prio (
    .opcode_i  (ExcOpcode),
    .overflow_i(ExcOverflow),
    .divzero_i (ExcDivZero),
    .cause_o   (req_cause),
    .vec_o     (req_vec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= StIdle;
      wait_cnt_q       <= '0;
      ExceptionAddress <= '0;
      ExcBusOwn        <= 1'b0;
      EPCOut           <= '0;
      EPCWrite         <= 1'b0;
      PCOut            <= '0;
      PCWrite          <= 1'b0;
      ExcCause         <= CAUSE_NONE;
      Busy             <= 1'b0;
      ExcDone          <= 1'b0;
    end else begin
      EPCWrite <= 1'b0;
      PCWrite  <= 1'b0;
      ExcDone  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_cause != CAUSE_NONE) begin
            ExcCause         <= req_cause;
            ExceptionAddress <= req_vec;
            EPCOut           <= PC - 32'd4;
            EPCWrite         <= 1'b1;
            ExcBusOwn        <= 1'b1;
            Busy             <= 1'b1;
            wait_cnt_q       <= WaitInit;
            state_q          <= StAddr;
          end
        end
        StAddr: state_q <= StWait;
        StWait: begin
          // Sampling on the exit edge of the last WAIT cycle lands the data after
          // MEM_LATENCY cycles of address hold, with PCOut valid alongside PCWrite.
          if (wait_cnt_q == 3'd0) begin
            PCOut   <= {24'b0, MemData[7:0]};
            PCWrite <= 1'b1;
            state_q <= StLoad;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        StLoad: begin
          ExcBusOwn <= 1'b0;
          ExcDone   <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          Busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: one instance at latency 1, one at latency 3.
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] MemData;
  logic        r1_opc, r1_ovf, r1_div, r3_ovf;

  logic [31:0] a1_addr, a1_epc, a1_pc, a3_addr, a3_epc, a3_pc;
  logic        a1_own, a1_epcw, a1_pcw, a1_busy, a1_done;
  logic        a3_own, a3_epcw, a3_pcw, a3_busy, a3_done;
  logic [1:0]  a1_cause, a3_cause;

  int total = 0;
  int bad   = 0;
  int cnt_a, cnt_b, cyc_pw, cyc_done;

  always #5 clk = ~clk;

  exception_sequencer #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .ExcOpcode(r1_opc), .ExcOverflow(r1_ovf),
    .ExcDivZero(r1_div), .PC(PC), .MemData(MemData), .ExceptionAddress(a1_addr),
    .ExcBusOwn(a1_own), .EPCOut(a1_epc), .EPCWrite(a1_epcw), .PCOut(a1_pc),
    .PCWrite(a1_pcw), .ExcCause(a1_cause), .Busy(a1_busy), .ExcDone(a1_done)
  );

  exception_sequencer #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .ExcOpcode(1'b0), .ExcOverflow(r3_ovf),
    .ExcDivZero(1'b0), .PC(PC), .MemData(MemData), .ExceptionAddress(a3_addr),
    .ExcBusOwn(a3_own), .EPCOut(a3_epc), .EPCWrite(a3_epcw), .PCOut(a3_pc),
    .PCWrite(a3_pcw), .ExcCause(a3_cause), .Busy(a3_busy), .ExcDone(a3_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; PC = '0; MemData = '0;
    r1_opc = 0; r1_ovf = 0; r1_div = 0; r3_ovf = 0;
    tick(); tick();
    chk("rst_addr", a1_addr, 32'd0);
    chk("rst_flags", {a1_own, a1_epcw, a1_pcw, a1_busy, a1_done, a1_cause}, 32'd0);
    chk("rst_epc_pc", a1_epc | a1_pc, 32'd0);
    reset = 1'b1;
    tick();

    // 1: overflow, latency 1
    PC = 32'h10; MemData = 32'h0000_0040; r1_ovf = 1;
    tick(); r1_ovf = 0;                                   // cycle 1: ADDR
    chk("t1_epc", a1_epc, 32'h0C);
    chk("t1_epcw", a1_epcw, 1);
    chk("t1_addr", a1_addr, 32'd254);
    chk("t1_cause", a1_cause, 2'b10);
    chk("t1_own_busy", {a1_own, a1_busy}, 2'b11);
    tick();                                               // cycle 2: WAIT
    chk("t1_c2_strobes", {a1_epcw, a1_pcw, a1_done}, 3'b000);
    tick();                                               // cycle 3: LOAD
    chk("t1_pcw", a1_pcw, 1);
    chk("t1_pcout", a1_pc, 32'h40);
    tick();                                               // cycle 4: DONE
    chk("t1_done", {a1_done, a1_own, a1_pcw}, 3'b100);
    tick();
    chk("t1_idle", {a1_busy, a1_done}, 2'b00);

    // 2: all three at once
    PC = 32'h100; r1_opc = 1; r1_ovf = 1; r1_div = 1;
    tick(); r1_opc = 0; r1_ovf = 0; r1_div = 0;
    chk("t2_cause", a1_cause, 2'b01);
    chk("t2_addr", a1_addr, 32'd253);
    cnt_a = 1; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a1_epcw) cnt_a++;
      if (a1_done) cnt_b++;
    end
    chk("t2_one_epcw", cnt_a, 1);
    chk("t2_one_done", cnt_b, 1);

    // 3: divide-by-zero with PC wrap
    PC = 32'h0; r1_div = 1;
    tick(); r1_div = 0;
    chk("t3_epc_wrap", a1_epc, 32'hFFFF_FFFC);
    chk("t3_addr", a1_addr, 32'd255);
    chk("t3_cause", a1_cause, 2'b11);
    repeat (5) tick();

    // 4: latency 3; bus held through ADDR, 3 WAIT cycles and LOAD
    MemData = 32'hAABB_CC7F; PC = 32'h2000; r3_ovf = 1;
    tick(); r3_ovf = 0;
    cnt_a = a3_own ? 1 : 0; cyc_pw = 0; cyc_done = 0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (a3_own) cnt_a++;
      if (a3_pcw) begin
        cyc_pw = i;
        chk("t4_pcout", a3_pc, 32'h0000_007F);
      end
      if (a3_done) cyc_done = i;
    end
    chk("t4_busown_cycles", cnt_a, 5);
    chk("t4_pcw_cycle", cyc_pw, 5);
    chk("t4_done_cycle", cyc_done, 6);
    chk("t4_epc", a3_epc, 32'h1FFC);

    // 5: opcode pulse while busy is dropped
    MemData = 32'h0000_0011; PC = 32'h44; r1_ovf = 1;
    tick(); r1_ovf = 0;
    tick(); r1_opc = 1;
    tick(); r1_opc = 0;
    cnt_b = 0; cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      if (a1_done) cnt_b++;
      if (a1_epcw) cnt_a++;
      tick();
    end
    chk("t5_one_done", cnt_b, 1);
    chk("t5_no_epcw", cnt_a, 0);
    chk("t5_cause", a1_cause, 2'b10);
    chk("t5_addr", a1_addr, 32'd254);

    // 6: reset during WAIT
    MemData = 32'h0000_0099; PC = 32'h80; r1_ovf = 1;
    tick(); r1_ovf = 0;                                   // ADDR
    tick();                                               // WAIT
    reset = 1'b0;
    tick();
    chk("t6_rst_flags", {a1_own, a1_epcw, a1_pcw, a1_busy, a1_done, a1_cause}, 32'd0);
    chk("t6_rst_regs", a1_addr | a1_epc | a1_pc, 32'd0);
    reset = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a1_pcw) cnt_a++;
    end
    chk("t6_no_pcw", cnt_a, 0);
    PC = 32'h20; MemData = 32'h0000_0033; r1_opc = 1;
    tick(); r1_opc = 0;
    chk("t6_new_epc", a1_epc, 32'h1C);
    chk("t6_new_addr", a1_addr, 32'd253);
    tick(); tick();
    chk("t6_new_pcw", {a1_pcw, a1_pc[7:0]}, {1'b1, 8'h33});
    tick();
    chk("t6_new_done", a1_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
